// File: rtl/vote_pkg.sv
// Shared constants, converter state encoding and 7-segment table for vote_display.
package vote_pkg;

  localparam int unsigned VAL_W = 12;
  localparam int unsigned BCD_W = 16;
  localparam int unsigned NDIG  = 4;
  localparam int unsigned SEG_W = 7;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned PRE_W = 16;
  localparam int unsigned DIG_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } conv_state_e;

  // Segment patterns {g,f,e,d,c,b,a}, active-high, all segments off.
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  // Digits 9 (MSB entry) down to 0 (LSB entry), active-high.
  localparam logic [9:0][SEG_W-1:0] SEG_TABLE = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Map a BCD nibble to its active-high pattern; non-decimal codes show blank.
  function automatic logic [SEG_W-1:0] seg_pattern(input logic [3:0] nib);
    logic [SEG_W-1:0] pat;
    pat = SEG_BLANK;
    if (nib <= 4'd9) pat = SEG_TABLE[nib];
    return pat;
  endfunction

endpackage

// File: rtl/vote_display_seg7_decode.sv
// Combinational nibble-to-segment decoder with a blanking override.
module seg7_decode
  import vote_pkg::*;
(
  input  logic [3:0]       nib,
  input  logic             blank,
  output logic [SEG_W-1:0] seg_c
);

  // Blank wins over the nibble value.
  always_comb begin
    seg_c = SEG_BLANK;
    if (!blank) seg_c = seg_pattern(nib);
  end

endmodule

// File: rtl/vote_display.sv
// Binary vote count -> BCD (serial double dabble) -> multiplexed 4-digit 7-segment display.
module vote_display
  import vote_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             Power,
  input  logic [VAL_W-1:0] value,
  output logic [SEG_W-1:0] seg,
  output logic [NDIG-1:0]  an,
  output logic [BCD_W-1:0] bcd,
  output logic             busy
);

  localparam logic [SEG_W-1:0] SEG_OFF = SEG_ACTIVE_LOW ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
  localparam logic [NDIG-1:0]  AN_OFF  = SEG_ACTIVE_LOW ? {NDIG{1'b1}}  : {NDIG{1'b0}};

  conv_state_e      state_q, state_d;
  logic [VAL_W-1:0] lat_q, lat_d;
  logic [VAL_W-1:0] sh_q, sh_d;
  logic [BCD_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic             busy_q, busy_d;
  logic [BCD_W-1:0] adj_c;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [DIG_W-1:0] dig_q, dig_d;
  logic [SEG_W-1:0] seg_q, seg_d;
  logic [NDIG-1:0]  an_q, an_d;
  logic [3:0]       nib_c;
  logic [DIG_W-1:0] msd_c;
  logic             blank_c;
  logic [NDIG-1:0]  an_on_c;
  logic [SEG_W-1:0] pat_c;

  // Converter state registers.
  always_ff @(posedge clk) begin
    if (Power) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
      sh_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      busy_q  <= busy_d;
    end
  end

  // Converter next state: capture on change, 12 add-3/shift steps, then publish.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    adj_c   = acc_q;
    for (int i = 0; i < int'(NDIG); i++) begin
      if (acc_q[i*4 +: 4] >= 4'd5) adj_c[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
    end
    case (state_q)
      ST_IDLE: begin
        if (value != lat_q) begin
          lat_d   = value;
          sh_d    = value;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        {acc_d, sh_d} = {adj_c[BCD_W-2:0], sh_q, 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_W'(VAL_W - 1)) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        bcd_d   = acc_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Highest non-zero digit of the published result; digit 0 is always shown.
  always_comb begin
    msd_c = '0;
    for (int i = 1; i < int'(NDIG); i++) begin
      if (bcd_q[i*4 +: 4] != 4'd0) msd_c = DIG_W'(i);
    end
  end

  // Digit mux over the published result.
  always_comb begin
    nib_c = bcd_q[3:0];
    case (dig_q)
      2'd1:    nib_c = bcd_q[7:4];
      2'd2:    nib_c = bcd_q[11:8];
      2'd3:    nib_c = bcd_q[15:12];
      default: nib_c = bcd_q[3:0];
    endcase
    blank_c = (dig_q > msd_c);
  end

  seg7_decode u_seg7_decode (
    .nib   (nib_c),
    .blank (blank_c),
    .seg_c (pat_c)
  );

  // Scan registers.
  always_ff @(posedge clk) begin
    if (Power) begin
      pre_q <= '0;
      dig_q <= '0;
      seg_q <= SEG_OFF;
      an_q  <= AN_OFF;
    end else begin
      pre_q <= pre_d;
      dig_q <= dig_d;
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  // Prescaler/digit advance and polarity-adjusted display drive.
  always_comb begin
    pre_d = pre_q + 16'd1;
    dig_d = dig_q;
    if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
      pre_d = '0;
      dig_d = dig_q + 2'd1;
    end
    an_on_c = 4'b0001 << dig_q;
    an_d    = SEG_ACTIVE_LOW ? ~an_on_c : an_on_c;
    seg_d   = SEG_ACTIVE_LOW ? ~pat_c : pat_c;
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign bcd  = bcd_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_vote_display.sv
// Directed bench for vote_display with a fast scan divider.
module tb_vote_display;

  logic        clk;
  logic        Power;
  logic [11:0] value;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] bcd;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  vote_display #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk   (clk),
    .Power (Power),
    .value (value),
    .seg   (seg),
    .an    (an),
    .bcd   (bcd),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Active-low reference patterns {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_ref(input logic [3:0] nib);
    case (nib)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Conversion already captured on the next edge: 13 busy samples, then result.
  task automatic run_conv(input string tag, input logic [15:0] exp_bcd);
    for (int k = 0; k < 13; k++) begin
      tick();
      check({tag, "_busy"}, 32'(busy), 32'd1);
    end
    tick();
    check({tag, "_bcd"}, 32'(bcd), 32'(exp_bcd));
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  // One full scan: every digit lit once with the right pattern or blank.
  task automatic scan_check(input string tag, input logic [15:0] exp_bcd);
    logic [3:0] seen;
    int         top;
    int         idx;
    logic [3:0] nib;
    logic [6:0] exp_seg;
    logic [15:0] b;
    b    = exp_bcd;
    seen = 4'b0000;
    top  = 0;
    for (int i = 1; i < 4; i++) if (b[i*4 +: 4] != 4'd0) top = i;
    for (int k = 0; k < 16; k++) begin
      tick();
      case (an)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      if (idx < 0) begin
        check({tag, "_an_onehot"}, 32'(an), 32'hE);
      end else begin
        seen[idx] = 1'b1;
        nib = b[idx*4 +: 4];
        exp_seg = (idx > top) ? 7'b1111111 : seg_ref(nib);
        check({tag, "_seg"}, 32'(seg), 32'(exp_seg));
      end
    end
    check({tag, "_all_digits"}, 32'(seen), 32'hF);
  endtask

  initial begin
    logic [3:0] exp_an;
    Power = 1'b1;
    value = 12'd0;

    // Reset with value 0.
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_an", 32'(an), 32'hF);
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_bcd", 32'(bcd), 32'h0);
    end
    Power = 1'b0;
    tick();
    check("rel_an", 32'(an), 32'hE);
    check("rel_seg0", 32'(seg), 32'h40);
    check("rel_bcd", 32'(bcd), 32'h0);
    check("rel_busy", 32'(busy), 32'd0);

    // Scan order with divider 4: observation k (from release) shows digit ((k-1)/4)%4.
    for (int k = 2; k <= 17; k++) begin
      tick();
      case (((k - 1) / 4) % 4)
        0: exp_an = 4'b1110;
        1: exp_an = 4'b1101;
        2: exp_an = 4'b1011;
        default: exp_an = 4'b0111;
      endcase
      check("scan_an", 32'(an), 32'(exp_an));
      check("scan_seg_zero", 32'(seg), (exp_an == 4'b1110) ? 32'h40 : 32'h7F);
    end

    // Full-scale value.
    value = 12'd4095;
    run_conv("v4095", 16'h4095);
    scan_check("v4095", 16'h4095);

    // Leading-zero blanking.
    value = 12'd7;
    run_conv("v7", 16'h0007);
    scan_check("v7", 16'h0007);

    // Change during conversion is picked up after the running one.
    value = 12'd123;
    for (int k = 0; k < 13; k++) begin
      tick();
      if (k == 4) value = 12'd456;
      check("v123_busy", 32'(busy), 32'd1);
    end
    tick();
    check("v123_bcd", 32'(bcd), 32'h0123);
    tick();
    check("v456_start", 32'(busy), 32'd1);
    for (int k = 0; k < 12; k++) tick();
    check("v456_old_held", 32'(bcd), 32'h0123);
    tick();
    tick();
    check("v456_bcd", 32'(bcd), 32'h0456);
    check("v456_idle", 32'(busy), 32'd0);

    // Reset mid-conversion aborts and restarts after release.
    value = 12'd999;
    for (int k = 0; k < 6; k++) tick();
    check("v999_busy_pre", 32'(busy), 32'd1);
    Power = 1'b1;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_bcd", 32'(bcd), 32'h0);
    check("abort_an", 32'(an), 32'hF);
    Power = 1'b0;
    run_conv("v999", 16'h0999);
    scan_check("v999", 16'h0999);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vote_display.md
VOTE_DISPLAY -- requirements
Module: vote_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clock cycles each digit is held before the scan advances (legal range 2..65535).
REQ-002 SHALL have parameter SEG_ACTIVE_LOW, default 1; when 1, seg and an outputs are active-low.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 Power  input  1  synchronous active-high reset.
REQ-006 value  input  12  binary count from the vote counter's out bus, 0..4095.
REQ-007 seg  output  7  segments {g,f,e,d,c,b,a} of the currently scanned digit.
REQ-008 an  output  4  digit enables; an[0] is the least significant digit.
REQ-009 bcd  output  16  last completed conversion, four BCD nibbles, [3:0] = ones.
REQ-010 busy  output  1  high while a conversion is in progress.

Function
REQ-011 SHALL hold a latched copy of value (lat) and convert it to BCD by shift-add-3 (double dabble), one bit per cycle.
REQ-012 Converter FSM states: IDLE, SHIFT, LOAD; encoding 2 bits.
REQ-013 IDLE: if value != lat, capture value into lat and shift register, clear BCD accumulator, go SHIFT; else stay.
REQ-014 SHIFT: each cycle, add 3 to every accumulator nibble >= 5, then shift left one bit from the shift register; after exactly 12 shifts go LOAD.
REQ-015 LOAD: copy accumulator to bcd, go IDLE; bcd changes only in this state.
REQ-016 Latency: value change sampled in IDLE at cycle t -> bcd valid at cycle t+14; busy high in cycles t+1..t+13.
REQ-017 A value change during SHIFT/LOAD SHALL NOT disturb the running conversion; it is picked up by the IDLE compare after LOAD (last value wins; intermediate values may be skipped).
REQ-018 Scan: a prescaler counts 0..SCAN_DIV-1; on wrap, digit index advances 0->1->2->3->0.
REQ-019 Exactly one an bit is active at a time, matching the digit index.
REQ-020 Leading-zero blanking: digits above the most significant non-zero nibble of bcd SHALL drive all segments off; digit 0 is never blanked (bcd=0 shows "0").
REQ-021 Segment patterns: standard 0-9; nibbles 10-15 (unreachable) SHALL display blank.
REQ-022 seg/an SHALL be registered; display reflects bcd, never the in-progress accumulator.

Reset
REQ-023 While Power is high at a clk edge: FSM->IDLE, lat=0, shift/accumulator=0, bcd=16'h0000, busy=0, prescaler=0, digit index=0, an all inactive, seg all off.
REQ-024 Power asserted mid-conversion SHALL abort it; bcd stays 0 until a new conversion completes.
REQ-025 First cycle after Power deasserts: an selects digit 0, seg shows "0"; if value != 0 a conversion starts that cycle.

Structure
REQ-026 Package vote_pkg SHALL hold FSM state constants, the 7-segment pattern table and SEG_BLANK.
REQ-027 One sub-module seg7_decode (4-bit nibble + blank flag -> 7 segments, combinational) SHALL be instantiated once after the digit mux.

Verification
REQ-028 Power high 3 cycles, value=0 -> an=4'b1111 during reset; after release bcd=16'h0000, busy=0, an=4'b1110, seg=0 pattern (active-low 7'b1000000).
REQ-029 value=4095 after reset -> busy for 13 cycles, bcd=16'h4095 at t+14, all four digits lit across one full scan.
REQ-030 value=7 -> bcd=16'h0007; digits 1-3 seg=7'b1111111 when scanned, digit 0 shows 7.
REQ-031 value=123, then value=456 at cycle t+5 -> bcd=16'h0123 at t+14, then 16'h0456 at t+29.
REQ-032 SCAN_DIV=4 -> an cycles 1110,1101,1011,0111,1110 changing every 4 clocks.
REQ-033 value=999, Power pulsed at t+6 -> busy=0, bcd=16'h0000 next cycle; conversion to 16'h0999 restarts after release.
